az_result_pair: RTL and testbench

Receive-side companion to the auto-zero modulation sequencer. It watches the sequencer's precharge switch control and AZ mux select, classifies each clock as signal, zero or settle, and accumulates ADC conversion results into a signal sum and a zero sum. Each completed signal→zero pair is emitted as one result word, with a valid/ready handshake, to the downstream reader or SPI register bank.

---
 rtl/az_result_pair.sv | 232 +++++++++++++++++++++++
 tb/tb_az_result_pair.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/az_result_pair.sv
// az_result_pair
//   Receive-side companion to the auto-zero modulation sequencer. Classifies
//   every clock as signal / zero / settle from the precharge switch control and
//   the AZ mux select, accumulates ADC results of each phase (after discarding
//   the first BLANK_N settling samples), and emits every completed
//   signal->zero pair as one result word over a valid/ready handshake.
//
// Ports
//   clk, reset    : system clock, asynchronous active-high reset
//   sw_pc_ctl     : precharge switch control (1 = signal, 0 = boot)
//   azmux         : AZ mux select
//   adc_valid     : one-cycle strobe qualifying adc_data
//   adc_data      : signed ADC conversion result
//   out_ready     : consumer accepts the current result
//   clear_flags   : clears the sticky overrun / seq_err flags
//   out_valid     : result registers hold an unconsumed pair
//   hi_sum/lo_sum : signal / zero phase sums
//   diff          : hi_sum - lo_sum (modulo 2^ACC_W)
//   hi_n/lo_n     : accepted sample counts of each phase
//   overrun       : sticky, a pair was dropped because the output was full
//   seq_err       : sticky, a signal phase restarted before any zero phase
//   monitor       : {5'b0, state}
module az_result_pair #(
    parameter logic [3:0] AZ_PC_OUT_CODE = 4'b1000,
    parameter int         DATA_W         = 24,
    parameter int         ACC_W          = 40,
    parameter int         CNT_W          = 16,
    parameter int         BLANK_N        = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sw_pc_ctl,
    input  logic [3:0]        azmux,
    input  logic              adc_valid,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              out_ready,
    input  logic              clear_flags,
    output logic              out_valid,
    output logic [ACC_W-1:0]  hi_sum,
    output logic [ACC_W-1:0]  lo_sum,
    output logic [ACC_W-1:0]  diff,
    output logic [CNT_W-1:0]  hi_n,
    output logic [CNT_W-1:0]  lo_n,
    output logic              overrun,
    output logic              seq_err,
    output logic [7:0]        monitor
);

    typedef enum logic [1:0] {
        CL_SETTLE = 2'd0,
        CL_SIG    = 2'd1,
        CL_ZERO   = 2'd2
    } class_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SIG_ACC   = 3'd1,
        WAIT_ZERO = 3'd2,
        ZERO_ACC  = 3'd3,
        EMIT      = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_N);

    state_t             state;
    class_t             prev_class;
    class_t             cur_class;

    logic [ACC_W-1:0]   hi_acc;
    logic [ACC_W-1:0]   lo_acc;
    logic [CNT_W-1:0]   hi_cnt;
    logic [CNT_W-1:0]   lo_cnt;
    logic [CNT_W-1:0]   blank_cnt;

    logic               sig_now;
    logic               zero_now;
    logic               sig_entry;
    logic               sig_exit;
    logic               zero_entry;
    logic               zero_exit;
    logic               in_blank;
    logic [ACC_W-1:0]   sample_ext;

    // Values a phase starts with when its entry cycle also carries a sample
    logic [CNT_W-1:0]   start_blank;
    logic [ACC_W-1:0]   start_acc;
    logic [CNT_W-1:0]   start_cnt;

    always_comb begin
        cur_class = CL_SETTLE;
        if (azmux != AZ_PC_OUT_CODE) begin
            cur_class = CL_ZERO;
        end else if (sw_pc_ctl) begin
            cur_class = CL_SIG;
        end
    end

    assign sig_now    = (cur_class == CL_SIG);
    assign zero_now   = (cur_class == CL_ZERO);
    assign sig_entry  = sig_now  && (prev_class != CL_SIG);
    assign sig_exit   = !sig_now && (prev_class == CL_SIG);
    assign zero_entry = zero_now && (prev_class != CL_ZERO);
    assign zero_exit  = !zero_now && (prev_class == CL_ZERO);

    assign in_blank   = (blank_cnt < BLANK_LIM);
    assign sample_ext = {{(ACC_W-DATA_W){adc_data[DATA_W-1]}}, adc_data};

    always_comb begin
        start_blank = '0;
        start_acc   = '0;
        start_cnt   = '0;
        if (adc_valid) begin
            if (BLANK_LIM != '0) begin
                start_blank = CNT_W'(1);
            end else begin
                start_acc = sample_ext;
                start_cnt = CNT_W'(1);
            end
        end
    end

    assign monitor = {5'b0, state};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            prev_class <= CL_SETTLE;
            hi_acc     <= '0;
            lo_acc     <= '0;
            hi_cnt     <= '0;
            lo_cnt     <= '0;
            blank_cnt  <= '0;
            out_valid  <= 1'b0;
            hi_sum     <= '0;
            lo_sum     <= '0;
            diff       <= '0;
            hi_n       <= '0;
            lo_n       <= '0;
            overrun    <= 1'b0;
            seq_err    <= 1'b0;
        end else begin
            prev_class <= cur_class;

            // Clear first so that a flag set or a load later in this block wins
            if (clear_flags) begin
                overrun <= 1'b0;
                seq_err <= 1'b0;
            end
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (sig_entry) begin
                        blank_cnt <= start_blank;
                        hi_acc    <= start_acc;
                        hi_cnt    <= start_cnt;
                        state     <= SIG_ACC;
                    end
                end

                SIG_ACC: begin
                    if (sig_exit) begin
                        state <= WAIT_ZERO;
                    end else if (adc_valid && sig_now) begin
                        if (in_blank) begin
                            blank_cnt <= blank_cnt + CNT_W'(1);
                        end else if (hi_cnt != '1) begin
                            hi_acc <= hi_acc + sample_ext;
                            hi_cnt <= hi_cnt + CNT_W'(1);
                        end
                    end
                end

                WAIT_ZERO: begin
                    if (zero_entry) begin
                        blank_cnt <= start_blank;
                        lo_acc    <= start_acc;
                        lo_cnt    <= start_cnt;
                        state     <= ZERO_ACC;
                    end else if (sig_entry) begin
                        // Signal phase restarted with no zero phase: drop hi
                        seq_err   <= 1'b1;
                        blank_cnt <= start_blank;
                        hi_acc    <= start_acc;
                        hi_cnt    <= start_cnt;
                        state     <= SIG_ACC;
                    end
                end

                ZERO_ACC: begin
                    if (zero_exit) begin
                        state <= EMIT;
                    end else if (adc_valid && zero_now) begin
                        if (in_blank) begin
                            blank_cnt <= blank_cnt + CNT_W'(1);
                        end else if (lo_cnt != '1) begin
                            lo_acc <= lo_acc + sample_ext;
                            lo_cnt <= lo_cnt + CNT_W'(1);
                        end
                    end
                end

                EMIT: begin
                    if (!out_valid || out_ready) begin
                        hi_sum    <= hi_acc;
                        lo_sum    <= lo_acc;
                        diff      <= hi_acc - lo_acc;
                        hi_n      <= hi_cnt;
                        lo_n      <= lo_cnt;
                        out_valid <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                    // A signal phase may begin in the emit cycle itself
                    if (sig_entry) begin
                        blank_cnt <= start_blank;
                        hi_acc    <= start_acc;
                        hi_cnt    <= start_cnt;
                        state     <= SIG_ACC;
                    end else begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_az_result_pair.sv
module tb_az_result_pair;

    localparam int DATA_W = 24;
    localparam int ACC_W  = 40;
    localparam int CNT_W  = 16;

    typedef int vec8_t [8];

    logic              clk = 1'b0;
    logic              reset;
    logic              sw_pc_ctl;
    logic [3:0]        azmux;
    logic              adc_valid;
    logic [DATA_W-1:0] adc_data;
    logic              out_ready;
    logic              clear_flags;
    logic              out_valid;
    logic [ACC_W-1:0]  hi_sum;
    logic [ACC_W-1:0]  lo_sum;
    logic [ACC_W-1:0]  diff;
    logic [CNT_W-1:0]  hi_n;
    logic [CNT_W-1:0]  lo_n;
    logic              overrun;
    logic              seq_err;
    logic [7:0]        monitor;

    int n_cmp = 0;
    int n_bad = 0;

    az_result_pair #(
        .AZ_PC_OUT_CODE(4'b1000),
        .DATA_W        (DATA_W),
        .ACC_W         (ACC_W),
        .CNT_W         (CNT_W),
        .BLANK_N       (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sw_pc_ctl  (sw_pc_ctl),
        .azmux      (azmux),
        .adc_valid  (adc_valid),
        .adc_data   (adc_data),
        .out_ready  (out_ready),
        .clear_flags(clear_flags),
        .out_valid  (out_valid),
        .hi_sum     (hi_sum),
        .lo_sum     (lo_sum),
        .diff       (diff),
        .hi_n       (hi_n),
        .lo_n       (lo_n),
        .overrun    (overrun),
        .seq_err    (seq_err),
        .monitor    (monitor)
    );

    always #5 clk = ~clk;

    // One clock with the given inputs; returns 1 time unit after the edge
    task automatic drive(input logic pc, input logic [3:0] mux, input logic av, input int d);
        sw_pc_ctl = pc;
        azmux     = mux;
        adc_valid = av;
        adc_data  = DATA_W'(d);
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        drive(1'b0, 4'b1000, 1'b0, 0);
    endtask

    task automatic sig_phase(input int n, input vec8_t v);
        for (int i = 0; i < n; i++) drive(1'b1, 4'b1000, 1'b1, v[i]);
    endtask

    task automatic zero_phase(input int n, input vec8_t v);
        for (int i = 0; i < n; i++) drive(1'b0, 4'b0000, 1'b1, v[i]);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        settle();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        n_cmp++; if (hi_sum !== '0 || lo_sum !== '0 || diff !== '0) begin n_bad++; $display("FAIL reset_sums got=%0h/%0h/%0h exp=0", hi_sum, lo_sum, diff); end
        n_cmp++; if (hi_n !== '0 || lo_n !== '0) begin n_bad++; $display("FAIL reset_counts got=%0d/%0d exp=0", hi_n, lo_n); end
        n_cmp++; if (overrun !== 1'b0 || seq_err !== 1'b0) begin n_bad++; $display("FAIL reset_flags got=%0b%0b exp=00", overrun, seq_err); end
        n_cmp++; if (monitor !== 8'd0) begin n_bad++; $display("FAIL reset_monitor got=%0d exp=0", monitor); end
        reset = 1'b0;
        settle();
    endtask

    task automatic test_basic();
        settle();
        sig_phase(5, '{100, 100, 5, 6, 7, 0, 0, 0});
        n_cmp++; if (monitor !== 8'd1) begin n_bad++; $display("FAIL basic_state_sig got=%0d exp=1", monitor); end
        settle();
        n_cmp++; if (monitor !== 8'd2) begin n_bad++; $display("FAIL basic_state_wait got=%0d exp=2", monitor); end
        zero_phase(5, '{100, 100, 1, 1, 1, 0, 0, 0});
        settle();  // zero exit cycle
        n_cmp++; if (out_valid !== 1'b0 || monitor !== 8'd4) begin n_bad++; $display("FAIL basic_emit_early got v=%0b st=%0d exp v=0 st=4", out_valid, monitor); end
        settle();  // emit cycle
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid got=%0b exp=1", out_valid); end
        n_cmp++; if (hi_sum !== 40'd18 || hi_n !== 16'd3) begin n_bad++; $display("FAIL basic_hi got=%0d n=%0d exp=18 n=3", hi_sum, hi_n); end
        n_cmp++; if (lo_sum !== 40'd3 || lo_n !== 16'd3) begin n_bad++; $display("FAIL basic_lo got=%0d n=%0d exp=3 n=3", lo_sum, lo_n); end
        n_cmp++; if (diff !== 40'd15) begin n_bad++; $display("FAIL basic_diff got=%0d exp=15", diff); end
        n_cmp++; if (monitor !== 8'd0) begin n_bad++; $display("FAIL basic_idle got=%0d exp=0", monitor); end
        settle();
        n_cmp++; if (out_valid !== 1'b1 || hi_sum !== 40'd18) begin n_bad++; $display("FAIL basic_hold got v=%0b hi=%0d exp v=1 hi=18", out_valid, hi_sum); end
        consume();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_consume got=%0b exp=0", out_valid); end
    endtask

    task automatic test_negative();
        logic [ACC_W-1:0] e_hi;
        logic [ACC_W-1:0] e_diff;
        e_hi   = -40'sd33554432;
        e_diff = -40'sd33554436;
        // two leading samples are consumed by blanking
        sig_phase(6, '{0, 0, -8388608, -8388608, -8388608, -8388608, 0, 0});
        settle();
        zero_phase(6, '{0, 0, 1, 1, 1, 1, 0, 0});
        settle();
        settle();
        n_cmp++; if (hi_sum !== e_hi || hi_n !== 16'd4) begin n_bad++; $display("FAIL neg_hi got=%0h n=%0d exp=%0h n=4", hi_sum, hi_n, e_hi); end
        n_cmp++; if (lo_sum !== 40'd4) begin n_bad++; $display("FAIL neg_lo got=%0d exp=4", lo_sum); end
        n_cmp++; if (diff !== e_diff) begin n_bad++; $display("FAIL neg_diff got=%0h exp=%0h", diff, e_diff); end
        consume();
    endtask

    task automatic test_overrun();
        sig_phase(3, '{0, 0, 10, 0, 0, 0, 0, 0});
        settle();
        zero_phase(3, '{0, 0, 2, 0, 0, 0, 0, 0});
        settle();
        settle();
        n_cmp++; if (out_valid !== 1'b1 || overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_first got v=%0b o=%0b exp v=1 o=0", out_valid, overrun); end
        sig_phase(3, '{0, 0, 50, 0, 0, 0, 0, 0});
        settle();
        zero_phase(3, '{0, 0, 7, 0, 0, 0, 0, 0});
        settle();
        settle();
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_flag got=%0b exp=1", overrun); end
        n_cmp++; if (hi_sum !== 40'd10 || lo_sum !== 40'd2 || diff !== 40'd8) begin n_bad++; $display("FAIL ovr_retain got=%0d/%0d/%0d exp=10/2/8", hi_sum, lo_sum, diff); end
        clear_flags = 1'b1;
        settle();
        clear_flags = 1'b0;
        n_cmp++; if (overrun !== 1'b0 || out_valid !== 1'b1) begin n_bad++; $display("FAIL ovr_clear got o=%0b v=%0b exp o=0 v=1", overrun, out_valid); end
        consume();
    endtask

    task automatic test_seq_err();
        sig_phase(3, '{0, 0, 99, 0, 0, 0, 0, 0});
        settle();
        sig_phase(4, '{0, 0, 3, 4, 0, 0, 0, 0});
        n_cmp++; if (seq_err !== 1'b1) begin n_bad++; $display("FAIL seq_flag got=%0b exp=1", seq_err); end
        settle();
        zero_phase(3, '{0, 0, 1, 0, 0, 0, 0, 0});
        settle();
        settle();
        n_cmp++; if (hi_sum !== 40'd7 || hi_n !== 16'd2) begin n_bad++; $display("FAIL seq_hi got=%0d n=%0d exp=7 n=2", hi_sum, hi_n); end
        n_cmp++; if (diff !== 40'd6 || lo_n !== 16'd1) begin n_bad++; $display("FAIL seq_diff got=%0d n=%0d exp=6 n=1", diff, lo_n); end
        clear_flags = 1'b1;
        settle();
        clear_flags = 1'b0;
        n_cmp++; if (seq_err !== 1'b0) begin n_bad++; $display("FAIL seq_clear got=%0b exp=0", seq_err); end
        // leave the pair unconsumed for the next scenario
    endtask

    task automatic test_back_to_back();
        sig_phase(3, '{0, 0, 20, 0, 0, 0, 0, 0});
        drive(1'b0, 4'b1000, 1'b1, 1000);  // sample in the signal exit cycle
        zero_phase(3, '{0, 0, 5, 0, 0, 0, 0, 0});
        settle();  // zero exit -> EMIT
        n_cmp++; if (out_valid !== 1'b1 || hi_sum !== 40'd7) begin n_bad++; $display("FAIL b2b_old_held got v=%0b hi=%0d exp v=1 hi=7", out_valid, hi_sum); end
        out_ready = 1'b1;
        drive(1'b1, 4'b1000, 1'b1, 0);  // emit cycle: consume + load + signal entry
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || overrun !== 1'b0) begin n_bad++; $display("FAIL b2b_valid got v=%0b o=%0b exp v=1 o=0", out_valid, overrun); end
        n_cmp++; if (hi_sum !== 40'd20 || hi_n !== 16'd1) begin n_bad++; $display("FAIL b2b_exit_sample got=%0d n=%0d exp=20 n=1", hi_sum, hi_n); end
        n_cmp++; if (diff !== 40'd15) begin n_bad++; $display("FAIL b2b_diff got=%0d exp=15", diff); end
        n_cmp++; if (monitor !== 8'd1) begin n_bad++; $display("FAIL b2b_restart got=%0d exp=1", monitor); end
        out_ready = 1'b1;
        sig_phase(2, '{0, 30, 0, 0, 0, 0, 0, 0});
        out_ready = 1'b0;
        settle();
        zero_phase(3, '{0, 0, 6, 0, 0, 0, 0, 0});
        settle();
        settle();
        n_cmp++; if (hi_sum !== 40'd30 || hi_n !== 16'd1 || diff !== 40'd24) begin n_bad++; $display("FAIL b2b_second got=%0d n=%0d d=%0d exp=30 n=1 d=24", hi_sum, hi_n, diff); end
        // left unconsumed so the reset below has something to clear
    endtask

    task automatic test_mid_reset();
        sig_phase(3, '{0, 0, 40, 0, 0, 0, 0, 0});
        settle();
        zero_phase(2, '{0, 0, 0, 0, 0, 0, 0, 0});
        n_cmp++; if (monitor !== 8'd3) begin n_bad++; $display("FAIL rst_pre_state got=%0d exp=3", monitor); end
        reset = 1'b1;
        #2;
        n_cmp++; if (out_valid !== 1'b0 || hi_sum !== '0 || diff !== '0 || hi_n !== '0) begin n_bad++; $display("FAIL rst_outputs got v=%0b hi=%0d d=%0d n=%0d exp 0", out_valid, hi_sum, diff, hi_n); end
        n_cmp++; if (monitor !== 8'd0) begin n_bad++; $display("FAIL rst_monitor got=%0d exp=0", monitor); end
        @(negedge clk);
        reset = 1'b0;
        settle();
        sig_phase(4, '{0, 0, 11, 12, 0, 0, 0, 0});
        settle();
        zero_phase(3, '{0, 0, 3, 0, 0, 0, 0, 0});
        settle();
        settle();
        n_cmp++; if (out_valid !== 1'b1 || hi_sum !== 40'd23 || hi_n !== 16'd2) begin n_bad++; $display("FAIL rst_next_hi got v=%0b hi=%0d n=%0d exp v=1 hi=23 n=2", out_valid, hi_sum, hi_n); end
        n_cmp++; if (lo_sum !== 40'd3 || diff !== 40'd20) begin n_bad++; $display("FAIL rst_next_diff got lo=%0d d=%0d exp lo=3 d=20", lo_sum, diff); end
    endtask

    initial begin
        sw_pc_ctl   = 1'b0;
        azmux       = 4'b1000;
        adc_valid   = 1'b0;
        adc_data    = '0;
        out_ready   = 1'b0;
        clear_flags = 1'b0;
        test_reset();
        test_basic();
        test_negative();
        test_overrun();
        test_seq_err();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
